mc_cpu_sequencer: RTL
=====================

// Module: mc_cpu_sequencer
// PURPOSE
//  Multi-cycle successor to the single-cycle CPU control path. It owns the PC and IR and
//  sequences each MIPS-subset instruction through FETCH/DECODE/EXEC/MEM/WB over req/ack
//  memory handshakes with wait states. It drives register-file, ALU and data-memory strobes
//  to an external datapath, and supports a memory timeout plus an illegal-opcode halt.
// PARAMETERS
//  ADDR_W      32   PC / memory address width (>= 8; low 2 bits always 0)
//  RESET_PC    0    PC value loaded on reset
//  MEM_TIMEOUT 15   max wait cycles for an ack before a bus error; 0 disables the timeout
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       synchronous reset, active-low
//  imem_req_o     out  1       instruction fetch request, held until ack
//  imem_addr_o    out  ADDR_W  fetch address (= pc_o)
//  imem_ack_i     in   1       fetch ack; may arrive in the same cycle as req
//  imem_rdata_i   in   32      instruction word, valid when imem_ack_i=1
//  dmem_req_o     out  1       data memory request (lw/sw), held until ack
//  dmem_we_o      out  1       1 = store; valid while dmem_req_o=1
//  dmem_ack_i     in   1       data ack
//  rs_data_i      in   32      RS register value (jr target)
//  alu_zero_i     in   1       ALU zero flag, sampled in EXEC
//  ir_o           out  32      latched instruction register
//  pc_o           out  ADDR_W  current PC
//  alu_en_o       out  1       high in EXEC: datapath operands valid
//  rf_we_o        out  1       register write strobe, 1 cycle in WB
//  rf_waddr_o     out  5       write register: rd (R-type), rt (I-type), 31 (jal)
//  rf_wsel_o      out  2       write data select: 0 ALU, 1 memory, 2 PC+4
//  retire_o       out  1       1-cycle pulse when an instruction completes
//  halted_o       out  1       sticky; set in HALT
//  bus_err_o      out  1       sticky; set when a memory timeout occurs
//  illegal_o      out  1       sticky; set when an opcode is not decoded
// BEHAVIOUR
//  Reset (rst_i=0 at a clock edge):
//   - pc<=RESET_PC, ir<=0, state<=FETCH; all strobes and sticky flags <=0.
//   - imem_req_o is 0 during reset and rises the first cycle after release.
//  Supported ops:
//   - R-type (op 0x00; funct 0x08 = jr), addi 0x08, slti 0x0A.
//   - beq 0x04, bne 0x05, lw 0x23, sw 0x2B, j 0x02, jal 0x03.
//  FETCH:
//   - imem_req_o=1 until imem_ack_i.
//   - On ack: ir<=imem_rdata_i, pc4<=pc+4 (mod 2^ADDR_W), go to DECODE.
//  DECODE (1 cycle):
//   - Illegal opcode -> HALT with illegal_o=1; pc is unchanged.
//   - Otherwise go to EXEC.
//  EXEC (1 cycle, alu_en_o=1):
//   - beq/bne: taken if alu_zero_i==1 (beq) or ==0 (bne). Taken: pc<=pc4+(sext(imm16)<<2);
//     not taken: pc<=pc4. Retire, go to FETCH.
//   - j: pc<={pc4[ADDR_W-1:28],ir[25:0],2'b00}, truncated to ADDR_W. Retire, go to FETCH.
//   - jr: pc<={rs_data_i[ADDR_W-1:2],2'b00}. Retire, go to FETCH.
//   - jal: pc<=jump target, go to WB with wsel=2, waddr=31.
//   - R-type / addi / slti: go to WB.
//   - lw / sw: go to MEM.
//  MEM:
//   - dmem_req_o=1, dmem_we_o=(sw) until dmem_ack_i.
//   - sw: on ack pc<=pc4, retire, go to FETCH.
//   - lw: on ack go to WB with wsel=1.
//  WB (1 cycle):
//   - rf_we_o=1 with waddr/wsel as above; wsel=0 for ALU ops.
//   - pc<=pc4 (except jal). Retire, go to FETCH.
//  Latency with zero-wait memory (ack in the req cycle):
//   - branch / j / jr: 3 cycles. R / addi / slti / jal / sw: 4 cycles. lw: 5 cycles.
//   - Each ack wait cycle adds 1.
//  Timeout:
//   - A wait counter clears on entry to FETCH/MEM and increments each cycle req=1 and ack=0.
//   - When it reaches MEM_TIMEOUT with no ack: drop req, go to HALT, bus_err_o=1.
//   - An ack in the same cycle the count hits the limit wins (no error).
//  HALT:
//   - Absorbing. All req/strobes are 0; only reset exits.
//  Invariants:
//   - retire_o is never asserted in the same cycle as halted_o rising.
//   - Reset mid-handshake drops req in the next cycle with no retire.
// TESTING
//  1. addi $1,$0,5 at pc=0, ack same cycle -> rf_we_o in cycle 4, waddr=1, wsel=0, pc=4, one retire.
//  2. beq taken, imm=0xFFFF, pc=0x10, zero=1 -> pc=0x10; same with bne -> pc=0x14; 3 cycles each.
//  3. lw with 2-cycle imem and 3-cycle dmem waits -> retire at cycle 10, wsel=1, waddr=rt.
//  4. jal at pc=0x40, target field 0x100 -> pc=0x400, waddr=31, wsel=2; jr with rs=0x403 -> pc=0x400.
//  5. MEM_TIMEOUT=4, no dmem ack on sw -> bus_err_o=1, halted_o=1, dmem_req_o=0 after 4 waits.
//  6. opcode 0x3F -> illegal_o=1, HALT; rst_i=0 for 1 cycle -> pc=RESET_PC, fetch resumes.

Source files
------------

// File: rtl/mc_cpu_sequencer.sv
// mc_cpu_sequencer: multi-cycle control path for a MIPS subset.
// Owns PC/IR and steps each instruction through FETCH/DECODE/EXEC/MEM/WB over req/ack memories.
module mc_cpu_sequencer #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       MEM_TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       rs_data_i,
    input  logic              alu_zero_i,
    output logic [31:0]       ir_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              alu_en_o,
    output logic              rf_we_o,
    output logic [4:0]        rf_waddr_o,
    output logic [1:0]        rf_wsel_o,
    output logic              retire_o,
    output logic              halted_o,
    output logic              bus_err_o,
    output logic              illegal_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pc4_q, pc4_d;
    logic [31:0]         ir_q, ir_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                run_q;
    logic                halted_q, halted_d;
    logic                bus_err_q, bus_err_d;
    logic                illegal_q, illegal_d;

    logic [5:0]          op;
    logic [5:0]          funct;
    logic                is_r, is_jr, is_j, is_jal, is_beq, is_bne;
    logic                is_addi, is_slti, is_lw, is_sw, legal;
    logic                br_taken;
    logic [ADDR_W-1:0]   br_tgt, j_tgt, jr_tgt;
    logic [WAIT_W-1:0]   wait_inc;
    logic                timeout_hit;

    assign op      = ir_q[31:26];
    assign funct   = ir_q[5:0];
    assign is_r    = (op == OP_RTYPE);
    assign is_jr   = is_r && (funct == FN_JR);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_addi = (op == OP_ADDI);
    assign is_slti = (op == OP_SLTI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign legal   = is_r | is_j | is_jal | is_beq | is_bne | is_addi | is_slti | is_lw | is_sw;

    assign br_taken = is_beq ? alu_zero_i : !alu_zero_i;
    assign br_tgt   = pc4_q + ADDR_W'($signed({{14{ir_q[15]}}, ir_q[15:0], 2'b00}));
    // Jump region bits come from pc4 above bit 27; narrower PCs just truncate the target.
    assign j_tgt    = (pc4_q & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({ir_q[25:0], 2'b00});
    assign jr_tgt   = ADDR_W'(rs_data_i & 32'hFFFF_FFFC);

    assign wait_inc    = wait_q + 1'b1;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == WAIT_LIM);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        ir_d       = ir_q;
        wait_d     = '0;
        halted_d   = halted_q;
        bus_err_d  = bus_err_q;
        illegal_d  = illegal_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        alu_en_o   = 1'b0;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wsel_o  = '0;
        retire_o   = 1'b0;

        case (state_q)
            S_FETCH: begin
                // run_q holds the fetch off for the first cycle out of reset.
                if (run_q) begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        ir_d    = imem_rdata_i;
                        pc4_d   = pc_q + ADDR_W'(4);
                        state_d = S_DECODE;
                    end else if (timeout_hit) begin
                        state_d   = S_HALT;
                        halted_d  = 1'b1;
                        bus_err_d = 1'b1;
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_d = wait_inc;
                    end
                end
            end

            S_DECODE: begin
                if (!legal) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_en_o = 1'b1;
                if (is_beq || is_bne) begin
                    pc_d     = br_taken ? br_tgt : pc4_q;
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_j) begin
                    pc_d     = j_tgt;
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jr) begin
                    pc_d     = jr_tgt;
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jal) begin
                    pc_d    = j_tgt;
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_sw;
                if (dmem_ack_i) begin
                    if (is_sw) begin
                        pc_d     = pc4_q;
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    bus_err_d = 1'b1;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_inc;
                end
            end

            S_WB: begin
                rf_we_o = 1'b1;
                if (is_jal) begin
                    rf_waddr_o = 5'd31;
                    rf_wsel_o  = 2'd2;
                end else begin
                    rf_waddr_o = is_r ? ir_q[15:11] : ir_q[20:16];
                    rf_wsel_o  = is_lw ? 2'd1 : 2'd0;
                    pc_d       = pc4_q;
                end
                retire_o = 1'b1;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            pc4_q     <= '0;
            ir_q      <= '0;
            wait_q    <= '0;
            run_q     <= 1'b0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc4_q     <= pc4_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            run_q     <= 1'b1;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign ir_o        = ir_q;
    assign halted_o    = halted_q;
    assign bus_err_o   = bus_err_q;
    assign illegal_o   = illegal_q;

endmodule
